inst_fetch_queue: RTL

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

---
 rtl/inst_fetch_queue.sv | 124 ++++++++++++
 1 files changed

// File: rtl/inst_fetch_queue.sv
`timescale 1ns/1ps
// inst_fetch_queue
//   Instruction fetch front end. Issues sequential fetch requests to an
//   in-order MMU and queues the returned {pc, data} pairs for decode. The
//   head of the queue is shown ahead with no read latency. FLUSH redirects
//   fetch to NEW_PC and discards every response still in flight.
//
// Ports
//   CLK          clock, all state updates on the rising edge
//   RST          synchronous active-high reset
//   FLUSH        redirect request; NEW_PC is the new fetch target
//   NEW_PC       redirect target (low two bits ignored)
//   STALL        decode not accepting; head entry is held
//   MEM_WAIT     MMU busy; no request issues
//   INST_RDEN    fetch request strobe
//   INST_RIADDR  fetch request address
//   INST_RVALID  MMU response valid (one per request, in order)
//   INST_ROADDR  address of the returned instruction
//   INST_RDATA   returned instruction word
//   INST_VALID   queue head valid toward decode
//   INST_PC      queue head PC
//   INST_DATA    queue head instruction
module inst_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FLUSH,
  input  logic [31:0] NEW_PC,
  input  logic        STALL,
  input  logic        MEM_WAIT,
  output logic        INST_RDEN,
  output logic [31:0] INST_RIADDR,
  input  logic        INST_RVALID,
  input  logic [31:0] INST_ROADDR,
  input  logic [31:0] INST_RDATA,
  output logic        INST_VALID,
  output logic [31:0] INST_PC,
  output logic [31:0] INST_DATA
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  // Discard counter is wider than the occupancy counters: back-to-back
  // flushes while the MMU is slow can leave more than DEPTH stale
  // responses in flight, since issue is limited only by count+pending.
  localparam int unsigned DW = CW + 2;

  logic [31:0]   req_pc;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] pending;
  logic [DW-1:0] drop;

  logic          issue;
  logic          push;
  logic          pop;
  logic          head_valid;
  logic [CW:0]   occupancy;

  logic          unused_new_pc_low;
  assign unused_new_pc_low = ^NEW_PC[1:0];

  always_comb begin
    occupancy  = {1'b0, count} + {1'b0, pending};
    issue      = !RST && !FLUSH && !MEM_WAIT && (occupancy < (CW+1)'(DEPTH));
    push       = !RST && !FLUSH && INST_RVALID && (drop == '0);
    head_valid = !RST && !FLUSH && (count != '0);
    pop        = head_valid && !STALL;
  end

  assign INST_RDEN   = issue;
  assign INST_RIADDR = req_pc;
  assign INST_VALID  = head_valid;
  assign INST_PC     = pc_mem[rd_ptr];
  assign INST_DATA   = data_mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (RST) begin
      req_pc  <= RESET_PC;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      pending <= '0;
      drop    <= '0;
    end else if (FLUSH) begin
      // Everything still outstanding becomes a discard; a response landing
      // this very cycle retires one of them immediately.
      req_pc  <= {NEW_PC[31:2], 2'b00};
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      pending <= '0;
      drop    <= drop + DW'(pending) - DW'(INST_RVALID);
    end else begin
      if (issue) begin
        req_pc <= req_pc + 32'd4;
      end
      if (INST_RVALID && (drop != '0)) begin
        drop <= drop - DW'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      pending <= pending + CW'(issue) - CW'(push);
      count   <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      pc_mem[wr_ptr]   <= INST_ROADDR;
      data_mem[wr_ptr] <= INST_RDATA;
    end
  end

endmodule
